// File: rtl/tick_gen_pkg.sv
// Shared types and helpers for the multi-channel tick generator.
package tick_gen_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Channel-select width; a single channel still gets a 1-bit select.
   function automatic int unsigned chw(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tick_gen_chan.sv
// One tick channel: IDLE/RUN/DONE control, 0..P counter, active/shadow period
// registers and registered tick, square-wave and busy outputs.
module tick_gen_chan
   import tick_gen_pkg::*;
#(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned RESET_PERIOD = 23999999
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             oneshot,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             tick,
   output logic             sq,
   output logic             busy
);

   state_t           state, state_n;
   logic [WIDTH-1:0] count, count_n;
   logic [WIDTH-1:0] active, active_n;
   logic [WIDTH-1:0] shadow, shadow_n;
   logic             mode, mode_n;
   logic             tick_n, sq_n, busy_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         count  <= '0;
         active <= WIDTH'(RESET_PERIOD);
         shadow <= WIDTH'(RESET_PERIOD);
         mode   <= 1'b0;
         tick   <= 1'b0;
         sq     <= 1'b0;
         busy   <= 1'b0;
      end else begin
         state  <= state_n;
         count  <= count_n;
         active <= active_n;
         shadow <= shadow_n;
         mode   <= mode_n;
         tick   <= tick_n;
         sq     <= sq_n;
         busy   <= busy_n;
      end
   end

   always_comb begin
      state_n  = state;
      count_n  = count;
      active_n = active;
      shadow_n = wr_en ? wr_data : shadow;
      mode_n   = mode;
      tick_n   = 1'b0;
      sq_n     = sq;

      unique case (state)
         IDLE: begin
            count_n = '0;
            if (wr_en) active_n = wr_data;
            if (en) begin
               state_n = RUN;
               mode_n  = oneshot;
            end
         end
         RUN: begin
            if (!en) begin
               state_n = IDLE;
               count_n = '0;
               sq_n    = 1'b0;
            end else if (count == active) begin
               // A write landing on the wrap edge bypasses the shadow so it
               // governs the period that starts here.
               tick_n   = 1'b1;
               sq_n     = ~sq;
               count_n  = '0;
               active_n = wr_en ? wr_data : shadow;
               state_n  = mode ? DONE : RUN;
            end else begin
               count_n = count + WIDTH'(1);
            end
         end
         DONE: begin
            count_n = '0;
            if (wr_en) active_n = wr_data;
            if (!en) begin
               state_n = IDLE;
               sq_n    = 1'b0;
            end
         end
         default: begin
            state_n = IDLE;
            count_n = '0;
            sq_n    = 1'b0;
         end
      endcase

      busy_n = (state_n == RUN);
   end

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel tick/enable generator: N_CH independent channels sharing one
// period write port.
module tick_gen_multi
   import tick_gen_pkg::*;
#(
   parameter  int unsigned N_CH         = 4,
   parameter  int unsigned WIDTH        = 32,
   parameter  int unsigned RESET_PERIOD = 23999999,
   localparam int unsigned CHW          = chw(N_CH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_CH-1:0]  en,
   input  logic [N_CH-1:0]  oneshot,
   input  logic             wr_en,
   input  logic [CHW-1:0]   wr_ch,
   input  logic [WIDTH-1:0] wr_data,
   output logic [N_CH-1:0]  tick,
   output logic [N_CH-1:0]  sq,
   output logic [N_CH-1:0]  busy
);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      // Exact match on an in-range index drops writes to wr_ch >= N_CH.
      localparam logic [CHW-1:0] IDX = CHW'(i);
      logic sel;

      assign sel = wr_en && (wr_ch == IDX);

      tick_gen_chan #(
         .WIDTH        (WIDTH),
         .RESET_PERIOD (RESET_PERIOD)
      ) u_chan (
         .clk     (clk),
         .rst_n   (rst_n),
         .en      (en[i]),
         .oneshot (oneshot[i]),
         .wr_en   (sel),
         .wr_data (wr_data),
         .tick    (tick[i]),
         .sq      (sq[i]),
         .busy    (busy[i])
      );
   end

endmodule

// File: doc/tick_gen_multi.md
Name: tick_gen_multi

Overview:
- Parametrised, multi-channel successor to the fixed one-second slow clock; replaces hard-wired divide-by-power-of-two strobes.
- Each channel has a runtime-loadable period, periodic or one-shot mode, a one-cycle tick strobe and a toggling square-wave output.
- Sits beside the system clock and feeds enables to display scanning, debouncing and timekeeping logic. It does not generate derived clocks.

Parameters:
- N_CH, 4, number of independent channels (1..16).
- WIDTH, 32, width of period register and counter.
- RESET_PERIOD, 23999999, period value loaded at reset; gives a 1 Hz tick on a 24 MHz clk.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- en  input  N_CH  per-channel run level.
- oneshot  input  N_CH  per-channel mode: 1 = one-shot, 0 = periodic. Sampled on the IDLE->RUN transition.
- wr_en  input  1  period write strobe.
- wr_ch  input  CHW  target channel, where CHW = max(1, clog2(N_CH)).
- wr_data  input  WIDTH  new period value P.
- tick  output  N_CH  registered one-cycle strobe per channel.
- sq  output  N_CH  registered square wave; toggles on every tick.
- busy  output  N_CH  high while the channel is in RUN.

Behaviour:
- Reset (rst_n low, async): per channel, active period = shadow period = RESET_PERIOD, count = 0, state IDLE. tick, sq and busy are all 0.
- Period semantics: the counter runs 0..P. Tick period = P+1 clk cycles. P = 0 gives a tick every cycle.
- Per-channel states: IDLE, RUN, DONE.
  - IDLE: count held at 0. If en[i] = 1 at an edge, go to RUN, count <= 0, and latch oneshot[i] into the mode register.
  - RUN: at each edge, if count == active period: tick <= 1, sq <= ~sq, count <= 0, active <= shadow. Next state is DONE if mode is one-shot, otherwise stay in RUN. Else count <= count + 1 and tick <= 0.
  - DONE: count held at 0, tick = 0, sq holds. Leave to IDLE only when en[i] = 0.
  - From RUN or DONE, en[i] = 0 at an edge goes to IDLE, count <= 0, tick <= 0, sq <= 0.
- Latency: en sampled high at edge E0 gives the first tick high in the cycle following edge E0+P+1.
- busy[i] = 1 exactly while the state is RUN (registered with the state).
- Writes:
  - wr_en with wr_ch < N_CH loads the shadow period of that channel.
  - If that channel is IDLE or DONE, active is loaded as well.
  - If the write coincides with a wrap edge, the written value becomes the active period for the period starting at that wrap (write wins over old shadow).
  - wr_ch >= N_CH: the write is ignored.
  - Active never changes mid-period, so count never exceeds the active period.
- Arithmetic: the counter is WIDTH bits and is unsigned. P = 2^WIDTH-1 is legal; the compare happens before the increment, so there is no overflow.
- Channels are fully independent. Identical P and simultaneous en produce phase-aligned ticks.

Decomposition:
- Package tick_gen_pkg: state enum (IDLE, RUN, DONE) and a chw function for the select width.
- Sub-module tick_gen_chan (one channel: state, counter, active/shadow regs, tick/sq/busy).
- Top level: generate loop over N_CH plus write-select decode.

Test Plan:
- Reset: rst_n low mid-run (async, not clock-aligned) -> tick/sq/busy go to 0 immediately. After release with en high and no writes, ch0 ticks first 24000000 cycles after enable (RESET_PERIOD+1), then every 24000000 cycles.
- Periodic: write P = 3 to ch1 while IDLE, raise en[1] at E0 -> tick[1] high in the cycles after E0+4, E0+8 and E0+12. sq[1] = 1,0,1 after each. busy[1] = 1 throughout.
- One-shot: P = 2 on ch2 with oneshot = 1 -> exactly one tick after E0+3, then busy = 0, state DONE, no further ticks. Drop en for one cycle and raise it again -> one more tick 3 cycles later.
- Mid-run reload: ch0 running with P = 5, write P = 1 at count = 2 -> remaining ticks at +3 (old period completes), then every 2 cycles. A write coinciding with the wrap edge takes effect immediately.
- Edges: P = 0 -> tick high every cycle and sq toggles every cycle. wr_ch = N_CH -> no register changes. en dropped when count == P -> no tick, sq cleared.
